// File: rtl/mem_stage.sv
// LC-3b pipeline MEM stage: performs loads/stores (including two-access LDI/STI)
// against the data cache port, stalls the front end while busy, and fills MEM/WB.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_indirect,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_aluresult,
  input  logic [15:0] mem_store_data,
  input  logic [15:0] mem_npc,
  input  logic [15:0] mem_ir,
  input  logic [2:0]  mem_drid,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [1:0]  dmem_wmask,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_drid,
  output logic [15:0] wb_npc,
  output logic [15:0] wb_ir,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] ptr;
  logic        mem_op;
  logic        complete;
  logic [7:0]  load_byte;
  logic [15:0] result;

  assign state_dbg = state;
  assign mem_op    = mem_valid & (mem_read | mem_write);
  assign load_byte = mem_address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

  // Handshake: a request (dmem_read or dmem_write with address/mask/data) is held
  // steady from the first ACCx cycle until the cycle dmem_resp pulses; dmem_resp
  // is a single-cycle completion and is ignored outside ACC1/ACC2.
  always_comb begin
    state_next   = state;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 16'h0000;
    dmem_wmask   = 2'b00;
    dmem_wdata   = 16'h0000;
    stall        = 1'b0;
    complete     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          state_next = ACC1;
        end
      end
      ACC1: begin
        dmem_read    = mem_read | mem_indirect;
        dmem_write   = mem_write & ~mem_indirect;
        dmem_address = {mem_address[15:1], 1'b0};
        if (mem_byte && !mem_indirect) begin
          dmem_wmask = mem_address[0] ? 2'b10 : 2'b01;
          dmem_wdata = {mem_store_data[7:0], mem_store_data[7:0]};
        end else begin
          dmem_wmask = 2'b11;
          dmem_wdata = mem_store_data;
        end
        stall = 1'b1;
        if (dmem_resp) begin
          if (mem_indirect) begin
            state_next = ACC2;
          end else begin
            stall      = 1'b0;
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      ACC2: begin
        dmem_read    = mem_read;
        dmem_write   = mem_write;
        dmem_address = {ptr[15:1], 1'b0};
        dmem_wmask   = 2'b11;
        dmem_wdata   = mem_store_data;
        stall        = 1'b1;
        if (dmem_resp) begin
          stall      = 1'b0;
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte loads only happen on the direct path; indirect accesses are always words.
  always_comb begin
    result = dmem_rdata;
    if (mem_write) begin
      result = mem_aluresult;
    end else if (mem_byte && !mem_indirect) begin
      result = {{8{load_byte[7]}}, load_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == ACC1 && dmem_resp && mem_indirect) begin
        ptr <= dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_data  <= 16'h0000;
      wb_drid  <= 3'd0;
      wb_npc   <= 16'h0000;
      wb_ir    <= 16'h0000;
    end else if (state == IDLE && !mem_op) begin
      wb_valid <= mem_valid;
      wb_data  <= mem_aluresult;
      wb_drid  <= mem_drid;
      wb_npc   <= mem_npc;
      wb_ir    <= mem_ir;
    end else if (complete) begin
      wb_valid <= 1'b1;
      wb_data  <= result;
      wb_drid  <= mem_drid;
      wb_npc   <= mem_npc;
      wb_ir    <= mem_ir;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed + light random bench for mem_stage; MEM/WB results are checked
// against an expected queue filled when each instruction is driven.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_read, mem_write, mem_byte, mem_indirect;
  logic [15:0] mem_address, mem_aluresult, mem_store_data, mem_npc, mem_ir;
  logic [2:0]  mem_drid;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [1:0]  dmem_wmask;
  logic        dmem_resp;
  logic        stall, wb_valid;
  logic [15:0] wb_data, wb_npc, wb_ir;
  logic [2:0]  wb_drid;
  logic [1:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // {drid, npc, ir, data}
  logic [50:0] exp_q[$];

  mem_stage dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .mem_indirect(mem_indirect),
    .mem_address(mem_address), .mem_aluresult(mem_aluresult),
    .mem_store_data(mem_store_data), .mem_npc(mem_npc), .mem_ir(mem_ir),
    .mem_drid(mem_drid),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_drid(wb_drid),
    .wb_npc(wb_npc), .wb_ir(wb_ir), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop on every live MEM/WB entry
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 16'(wb_valid), 16'h0);
      end else begin
        logic [50:0] e;
        e = exp_q.pop_front();
        chk("wb_data", wb_data, e[15:0]);
        chk("wb_ir", wb_ir, e[31:16]);
        chk("wb_npc", wb_npc, e[47:32]);
        chk("wb_drid", 16'(wb_drid), 16'(e[50:48]));
      end
    end
  end

  task automatic clear_inputs();
    mem_valid = 0; mem_read = 0; mem_write = 0; mem_byte = 0; mem_indirect = 0;
    dmem_resp = 0;
  endtask

  // driver: non-memory instruction
  task automatic alu_op(input logic [15:0] alu, input logic [2:0] drid);
    mem_valid = 1; mem_read = 0; mem_write = 0; mem_byte = 0; mem_indirect = 0;
    mem_aluresult = alu; mem_drid = drid;
    mem_npc = 16'($urandom); mem_ir = 16'($urandom);
    exp_q.push_back({drid, mem_npc, mem_ir, alu});
    @(negedge clk);
    chk("alu_stall", 16'(stall), 16'h0);
    chk("alu_req", 16'({dmem_read, dmem_write}), 16'h0);
    next_cycle();
  endtask

  // driver: load/store with n1 (and for indirect n2) cycles of response latency
  task automatic mem_op(input string tag, input logic rd, input logic wr,
                        input logic byt, input logic ind, input logic [15:0] addr,
                        input logic [15:0] sd, input logic [15:0] alu,
                        input logic [2:0] drid, input int n1, input logic [15:0] rd1,
                        input int n2, input logic [15:0] rd2, input logic [1:0] mask1,
                        input logic [15:0] wdata1, input logic [15:0] exp_wb);
    logic [15:0] a1, a2;
    a1 = {addr[15:1], 1'b0};
    a2 = {rd1[15:1], 1'b0};
    mem_valid = 1; mem_read = rd; mem_write = wr; mem_byte = byt; mem_indirect = ind;
    mem_address = addr; mem_store_data = sd; mem_aluresult = alu; mem_drid = drid;
    mem_npc = addr + 16'd2; mem_ir = 16'($urandom);
    @(negedge clk);
    chk({tag, ":entry_stall"}, 16'(stall), 16'h1);
    chk({tag, ":entry_noreq"}, 16'({dmem_read, dmem_write}), 16'h0);
    next_cycle();
    for (int k = 1; k <= n1; k++) begin
      dmem_resp  = (k == n1);
      dmem_rdata = (k == n1) ? rd1 : 16'($urandom);
      if (k == n1 && !ind) exp_q.push_back({drid, mem_npc, mem_ir, exp_wb});
      @(negedge clk);
      if (k == 1) chk({tag, ":bubble"}, 16'(wb_valid), 16'h0);
      chk({tag, ":a1_read"}, 16'(dmem_read), 16'(rd | ind));
      chk({tag, ":a1_write"}, 16'(dmem_write), 16'(wr & ~ind));
      chk({tag, ":a1_addr"}, dmem_address, a1);
      if (wr && !ind) begin
        chk({tag, ":a1_mask"}, 16'(dmem_wmask), 16'(mask1));
        chk({tag, ":a1_wdata"}, dmem_wdata, wdata1);
      end
      chk({tag, ":a1_stall"}, 16'(stall), (k == n1 && !ind) ? 16'h0 : 16'h1);
      next_cycle();
    end
    dmem_resp = 0;
    if (ind) begin
      for (int k = 1; k <= n2; k++) begin
        dmem_resp  = (k == n2);
        dmem_rdata = (k == n2) ? rd2 : 16'($urandom);
        if (k == n2) exp_q.push_back({drid, mem_npc, mem_ir, exp_wb});
        @(negedge clk);
        chk({tag, ":a2_read"}, 16'(dmem_read), 16'(rd));
        chk({tag, ":a2_write"}, 16'(dmem_write), 16'(wr));
        chk({tag, ":a2_addr"}, dmem_address, a2);
        if (wr) begin
          chk({tag, ":a2_mask"}, 16'(dmem_wmask), 16'h3);
          chk({tag, ":a2_wdata"}, dmem_wdata, sd);
        end
        chk({tag, ":a2_stall"}, 16'(stall), (k == n2) ? 16'h0 : 16'h1);
        next_cycle();
      end
      dmem_resp = 0;
    end
    clear_inputs();
    @(negedge clk);
    chk({tag, ":req_drop"}, 16'({dmem_read, dmem_write}), 16'h0);
    chk({tag, ":idle"}, 16'(state_dbg), 16'h0);
    next_cycle();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    mem_address = 0; mem_aluresult = 0; mem_store_data = 0;
    mem_npc = 0; mem_ir = 0; mem_drid = 0; dmem_rdata = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_wb_valid", 16'(wb_valid), 16'h0);
    chk("rst_wb_data", wb_data, 16'h0);
    chk("rst_wb_drid", 16'(wb_drid), 16'h0);
    chk("rst_wb_npc", wb_npc, 16'h0);
    chk("rst_wb_ir", wb_ir, 16'h0);
    chk("rst_state", 16'(state_dbg), 16'h0);
    next_cycle();
    reset = 0;
    @(negedge clk);
    chk("post_rst_stall", 16'(stall), 16'h0);
    chk("post_rst_req", 16'({dmem_read, dmem_write}), 16'h0);
    next_cycle();

    // ADD passthrough, then a short random burst of ALU ops
    alu_op(16'h1234, 3'd3);
    for (int i = 0; i < 4; i++) alu_op(16'($urandom), 3'($urandom_range(0, 7)));
    clear_inputs();
    next_cycle();

    //     tag     rd wr by in addr      sd        alu       dr n1 rd1       n2 rd2       mask  wdata1    exp_wb
    mem_op("ldw",  1, 0, 0, 0, 16'h3001, 16'h0000, 16'h0000, 1, 3, 16'hBEEF, 0, 16'h0000, 2'b11, 16'h0000, 16'hBEEF);
    mem_op("ldbh", 1, 0, 1, 0, 16'h4003, 16'h0000, 16'h0000, 2, 1, 16'h80FF, 0, 16'h0000, 2'b11, 16'h0000, 16'hFF80);
    mem_op("ldbl", 1, 0, 1, 0, 16'h4002, 16'h0000, 16'h0000, 2, 2, 16'h807F, 0, 16'h0000, 2'b11, 16'h0000, 16'h007F);
    mem_op("stb",  0, 1, 1, 0, 16'h5001, 16'h00AB, 16'h0777, 0, 2, 16'h0000, 0, 16'h0000, 2'b10, 16'hABAB, 16'h0777);
    mem_op("stbl", 0, 1, 1, 0, 16'h5000, 16'h12CD, 16'h0778, 0, 1, 16'h0000, 0, 16'h0000, 2'b01, 16'hCDCD, 16'h0778);
    mem_op("stw",  0, 1, 0, 0, 16'h5003, 16'hA5C3, 16'h0779, 0, 2, 16'h0000, 0, 16'h0000, 2'b11, 16'hA5C3, 16'h0779);
    mem_op("ldi",  1, 0, 0, 1, 16'h6000, 16'h0000, 16'h0000, 5, 2, 16'h7002, 3, 16'h55AA, 2'b11, 16'h0000, 16'h55AA);
    mem_op("sti",  0, 1, 0, 1, 16'h6000, 16'h3C3C, 16'h0AAA, 6, 1, 16'h7002, 2, 16'h0000, 2'b11, 16'h0000, 16'h0AAA);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      mem_op("ldw_rand", 1, 0, 0, 0, 16'($urandom), 16'h0, 16'h0, 3'($urandom_range(0, 7)),
             $urandom_range(1, 4), r, 0, 16'h0, 2'b11, 16'h0, r);
    end
    alu_op(16'hCAFE, 3'd7);
    clear_inputs();
    next_cycle();

    // reset while an LDW request is outstanding; a late response must be ignored
    mem_valid = 1; mem_read = 1; mem_address = 16'h3001; mem_drid = 3'd2;
    next_cycle();
    @(negedge clk);
    chk("rst_acc1_read", 16'(dmem_read), 16'h1);
    #1 reset = 1;
    next_cycle();
    reset = 0;
    clear_inputs();
    @(negedge clk);
    chk("rst_acc1_read_drop", 16'(dmem_read), 16'h0);
    chk("rst_acc1_wb_valid", 16'(wb_valid), 16'h0);
    chk("rst_acc1_state", 16'(state_dbg), 16'h0);
    next_cycle();
    dmem_resp = 1; dmem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("stray_resp_stall", 16'(stall), 16'h0);
    chk("stray_resp_req", 16'({dmem_read, dmem_write}), 16'h0);
    next_cycle();
    dmem_resp = 0;
    @(negedge clk);
    chk("stray_resp_wb_valid", 16'(wb_valid), 16'h0);
    chk("stray_resp_state", 16'(state_dbg), 16'h0);
    next_cycle();

    @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage of the LC-3b core. It consumes the AGEX/MEM pipeline register (effective address, ALU result, store data, destination and control) and performs loads and stores against the data-side cache port with a request/response handshake. LDI/STI take two accesses. While an access is in flight it stalls the front of the pipeline, and it delivers each completed instruction into the MEM/WB register.

## Interface
Parameters: none.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: AGEX/MEM register holds a live instruction.
- `mem_read` in 1: load (LDB/LDW/LDI).
- `mem_write` in 1: store (STB/STW/STI).
- `mem_byte` in 1: byte access (LDB/STB); ignored when `mem_indirect`=1.
- `mem_indirect` in 1: LDI/STI; first access fetches a pointer.
- `mem_address` in 16: effective address from AGEX.
- `mem_aluresult` in 16: result for non-memory instructions.
- `mem_store_data` in 16: SR value for stores.
- `mem_npc` in 16, `mem_ir` in 16: passed through.
- `mem_drid` in 3: destination register id.
- `dmem_read` out 1, `dmem_write` out 1: cache request strobes.
- `dmem_address` out 16: word-aligned, bit 0 = 0.
- `dmem_wmask` out 2: byte enables, where bit1 = high byte.
- `dmem_wdata` out 16: store data.
- `dmem_rdata` in 16: read data, valid when `dmem_resp`=1.
- `dmem_resp` in 1: one-cycle completion pulse.
- `stall` out 1: hold AGEX/MEM and all earlier stages.
- `wb_valid` out 1: MEM/WB register holds a live instruction.
- `wb_data` out 16, `wb_drid` out 3, `wb_npc` out 16, `wb_ir` out 16: MEM/WB register contents.

## Operation
States:
- IDLE: no access in flight.
- ACC1: first access, at `mem_address`.
- ACC2: indirect second access, at the latched pointer.

Transitions:
- IDLE, `mem_valid` & (`mem_read`|`mem_write`):
  - Go to ACC1; `stall`=1; no request is driven this cycle.
  - MEM/WB is loaded with a bubble (`wb_valid`=0).
- IDLE, otherwise:
  - `stall`=0; MEM/WB loads `wb_valid`=`mem_valid`, `wb_data`=`mem_aluresult`, plus drid/npc/ir.
- ACC1, request:
  - `dmem_read`=`mem_read`|`mem_indirect`.
  - `dmem_write`=`mem_write`&~`mem_indirect`.
  - `dmem_address`={`mem_address`[15:1],0}.
  - Request held steady until `dmem_resp`.
- ACC1, `dmem_resp` & `mem_indirect`:
  - Latch `ptr`=`dmem_rdata`; go to ACC2; `stall` stays 1.
- ACC1, `dmem_resp` & ~`mem_indirect`:
  - `stall`=0 in that same cycle (combinational on `dmem_resp`).
  - MEM/WB loads the completed result with `wb_valid`=1; go to IDLE.
- ACC2, request:
  - `dmem_read`=`mem_read`, `dmem_write`=`mem_write`.
  - `dmem_address`={`ptr`[15:1],0}; word access, `dmem_wmask`=11.
- ACC2, `dmem_resp`:
  - Same completion as ACC1: `stall`=0, MEM/WB load, go to IDLE.

Data rules:
- Word store: `dmem_wmask`=11, `dmem_wdata`=`mem_store_data`.
- Byte store: `dmem_wdata`={SD[7:0],SD[7:0]}; `dmem_wmask`=10 if addr[0]=1, else 01.
- Load word: `wb_data`=`dmem_rdata`.
- Load byte: selected byte (addr[0]=1 gives [15:8], 0 gives [7:0]), sign-extended to 16 bits.
- Store completion: `wb_data`=`mem_aluresult`. WB gates the register write on `mem_ir`.
- `mem_read` and `mem_write` both 1 is illegal; behaviour is unspecified.
- `dmem_resp` while in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `wb_valid`=0; `wb_data`, `wb_drid`, `wb_npc`, `wb_ir` all 0; `ptr`=0.
  - `dmem_read`, `dmem_write`, `stall` are 0 the cycle after reset, provided no memory op is presented.
- Reset mid-access:
  - Next cycle is IDLE with requests deasserted.
  - A late `dmem_resp` is then ignored.
- Latency from entry to MEM/WB:
  - Non-memory op: 1 cycle, no stall.
  - Single access: 1 + N cycles, where N is cycles to `dmem_resp` (N≥1).
  - Indirect: 1 + N1 + N2 cycles.
- `stall` and the MEM inputs:
  - While `stall`=1, upstream holds all MEM inputs constant.
  - The next instruction appears on the cycle after `stall`=0.
- Request strobes fall the cycle after `dmem_resp`; there are no back-to-back requests without an IDLE cycle between them.

## Test plan
- **ADD passthrough:** `mem_valid`=1, no read/write, aluresult=x1234, drid=3 → next cycle `wb_valid`=1, `wb_data`=x1234, `wb_drid`=3; `stall` never 1.
- **LDW:** address x3001, resp after 3 cycles with rdata xBEEF → `dmem_address`=x3000, `dmem_read` held 3 cycles, `wb_data`=xBEEF; `stall` high for 3 cycles, low on the resp cycle.
- **LDB high byte:** address x4003, rdata x80FF → `wb_data`=xFF80. Repeat at x4002 with rdata x807F → `wb_data`=x007F.
- **STB:** address x5001, SD=x00AB → `dmem_wmask`=10, `dmem_wdata`=xABAB, `dmem_write`=1, `dmem_read`=0; completes with `wb_valid`=1.
- **LDI / STI:**
  - LDI: x6000 returns x7002, then x7002 returns x55AA → two requests at x6000 then x7002, `wb_data`=x55AA, `stall` continuous until the second resp.
  - STI: same pointer; second access is a write at x7002, wmask 11.
- **Reset in ACC1:** assert `reset` while `dmem_read`=1 → next cycle `dmem_read`=0, `wb_valid`=0, state IDLE; a subsequent stray `dmem_resp` has no effect.
